switch: RTL and testbench

SWITCH -- requirements
Module: switch

---
 rtl/switch_pkg.sv | 11 +
 rtl/switch_match.sv | 34 +++
 rtl/switch.sv | 99 +++++++++
 tb/tb_switch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and default sizing for the core-to-core switch.
// A lane holds the IEEE-754 single-precision bit pattern of a shortreal, so the datapath is plain bits.
package switch_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 16;
    localparam int unsigned DEFAULT_CORE_SIZE = 8;

    typedef logic [31:0] lane_t;
    typedef lane_t [DEFAULT_WIDTH-1:0] payload_t;

endpackage

// File: rtl/switch_match.sv
// Match finder for one receiver: flags which sender (at most one) reciprocally targets it this cycle.
module switch_match
    import switch_pkg::*;
#(
    parameter int unsigned CORE_SIZE      = DEFAULT_CORE_SIZE,
    parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE),
    parameter int unsigned RECV_IDX       = 0
) (
    input  logic [CORE_SIZE-1:0]                     send_ready_i,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] send_core_idx_i,
    input  logic [CORE_SIZE-1:0]                     send_ok_i,
    input  logic                                     recv_request_i,
    input  logic [CORE_ADDR_SIZE-1:0]                recv_core_idx_i,
    input  logic                                     recv_ready_i,
    output logic [CORE_SIZE-1:0]                     match_o,
    output logic                                     hit_o,
    output logic [CORE_ADDR_SIZE-1:0]                src_o
);

    // Indices outside 0..CORE_SIZE-1 never equal a loop index, so they cannot match.
    always_comb begin
        match_o = '0;
        for (int unsigned i = 0; i < CORE_SIZE; i++) begin
            match_o[i] = recv_request_i && !recv_ready_i
                       && (32'(recv_core_idx_i) == i)
                       && send_ready_i[i] && !send_ok_i[i]
                       && (32'(send_core_idx_i[i]) == RECV_IDX);
        end
    end

    assign hit_o = |match_o;
    assign src_o = recv_core_idx_i;

endmodule

// File: rtl/switch.sv
// Core-to-core switch: reciprocal send/receive requests complete one clock later, all pairs in parallel.
// Optional per-receiver transfer counters are enabled with macro SWITCH_XFER_COUNT_EN.
module switch
    import switch_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned CORE_SIZE      = DEFAULT_CORE_SIZE,
    parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [CORE_SIZE-1:0]                     send_ready,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] send_core_idx,
    input  lane_t [CORE_SIZE-1:0][WIDTH-1:0]         send_data,
    output logic [CORE_SIZE-1:0]                     send_ok,
    input  logic [CORE_SIZE-1:0]                     recv_request,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] recv_core_idx,
    output logic [CORE_SIZE-1:0]                     recv_ready,
    output lane_t [CORE_SIZE-1:0][WIDTH-1:0]         recv_data
`ifdef SWITCH_XFER_COUNT_EN
    ,
    output logic [CORE_SIZE-1:0][31:0]               xfer_count
`endif
);

    logic [CORE_SIZE-1:0][CORE_SIZE-1:0]      match;  // [receiver][sender]
    logic [CORE_SIZE-1:0]                     hit;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] src;

    logic [CORE_SIZE-1:0]             send_ok_d, send_ok_q;
    logic [CORE_SIZE-1:0]             recv_ready_d, recv_ready_q;
    lane_t [CORE_SIZE-1:0][WIDTH-1:0] recv_data_d, recv_data_q;

    for (genvar j = 0; j < CORE_SIZE; j++) begin : g_match
        switch_match #(
            .CORE_SIZE      (CORE_SIZE),
            .CORE_ADDR_SIZE (CORE_ADDR_SIZE),
            .RECV_IDX       (j)
        ) u_match (
            .send_ready_i    (send_ready),
            .send_core_idx_i (send_core_idx),
            .send_ok_i       (send_ok_q),
            .recv_request_i  (recv_request[j]),
            .recv_core_idx_i (recv_core_idx[j]),
            .recv_ready_i    (recv_ready_q[j]),
            .match_o         (match[j]),
            .hit_o           (hit[j]),
            .src_o           (src[j])
        );
    end

    always_comb begin
        send_ok_d    = '0;
        recv_ready_d = hit;
        recv_data_d  = recv_data_q;
        for (int unsigned j = 0; j < CORE_SIZE; j++) begin
            send_ok_d = send_ok_d | match[j];
            if (hit[j]) begin
                recv_data_d[j] = send_data[src[j]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            send_ok_q    <= '0;
            recv_ready_q <= '0;
            recv_data_q  <= '0;
        end else begin
            send_ok_q    <= send_ok_d;
            recv_ready_q <= recv_ready_d;
            recv_data_q  <= recv_data_d;
        end
    end

    assign send_ok    = send_ok_q;
    assign recv_ready = recv_ready_q;
    assign recv_data  = recv_data_q;

`ifdef SWITCH_XFER_COUNT_EN
    logic [CORE_SIZE-1:0][31:0] xfer_count_q;

    // Counts advance on the same edge the recv_ready pulse is registered; wrap is natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            xfer_count_q <= '0;
        end else begin
            for (int unsigned j = 0; j < CORE_SIZE; j++) begin
                if (recv_ready_d[j]) begin
                    xfer_count_q[j] <= xfer_count_q[j] + 32'd1;
                end
            end
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_switch.sv
// Self-checking bench for switch: directed scenarios plus randomized traffic against a transfer model.
module tb_switch;
    import switch_pkg::*;

    localparam int W = DEFAULT_WIDTH;
    localparam int N = DEFAULT_CORE_SIZE;
    localparam int A = $clog2(N);

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N-1:0]          send_ready, recv_request, send_ok, recv_ready;
    logic [N-1:0][A-1:0]   send_core_idx, recv_core_idx;
    lane_t [N-1:0][W-1:0]  send_data, recv_data;
`ifdef SWITCH_XFER_COUNT_EN
    logic [N-1:0][31:0]    xfer_count;
    logic [N-1:0][31:0]    exp_cnt;
`endif

    logic [N-1:0]          exp_ok, exp_rdy;
    lane_t [N-1:0][W-1:0]  exp_data;
    int                    n_cmp = 0;
    int                    n_bad = 0;

    switch u_dut (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (send_ready),
        .send_core_idx (send_core_idx),
        .send_data     (send_data),
        .send_ok       (send_ok),
        .recv_request  (recv_request),
        .recv_core_idx (recv_core_idx),
        .recv_ready    (recv_ready),
        .recv_data     (recv_data)
`ifdef SWITCH_XFER_COUNT_EN
        ,
        .xfer_count    (xfer_count)
`endif
    );

    always #5 clock = ~clock;

    // IEEE-754 single bit pattern of a small positive integer.
    function automatic lane_t flt(int unsigned n);
        int unsigned e;
        lane_t       r;
        e = 0;
        for (int b = 0; b < 32; b++) if (n[b]) e = b;
        r[31]    = 1'b0;
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'((n - (32'd1 << e)) << (23 - e));
        return r;
    endfunction

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        n_cmp++;
        assert (send_ok === exp_ok) else begin
            n_bad++;
            $error("FAIL %s send_ok observed=%b expected=%b", tag, send_ok, exp_ok);
        end
        n_cmp++;
        assert (recv_ready === exp_rdy) else begin
            n_bad++;
            $error("FAIL %s recv_ready observed=%b expected=%b", tag, recv_ready, exp_rdy);
        end
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            assert (recv_data[j] === exp_data[j]) else begin
                n_bad++;
                $error("FAIL %s recv_data[%0d] observed=%h expected=%h",
                       tag, j, recv_data[j], exp_data[j]);
            end
        end
`ifdef SWITCH_XFER_COUNT_EN
        n_cmp++;
        assert (xfer_count === exp_cnt) else begin
            n_bad++;
            $error("FAIL %s xfer_count observed=%h expected=%h", tag, xfer_count, exp_cnt);
        end
`endif
    endtask

    // Model: a transfer happens for every reciprocal pair whose ends are both idle this cycle.
    task automatic tick(string tag);
        logic [N-1:0]         nok, nrdy;
        lane_t [N-1:0][W-1:0] ndata;
        nok   = '0;
        nrdy  = '0;
        ndata = exp_data;
        if (reset) begin
            ndata = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (send_ready[i] && recv_request[j] && int'(send_core_idx[i]) == j
                        && int'(recv_core_idx[j]) == i && !exp_ok[i] && !exp_rdy[j]) begin
                        nok[i]   = 1'b1;
                        nrdy[j]  = 1'b1;
                        ndata[j] = send_data[i];
                    end
                end
            end
        end
        @(posedge clock);
        exp_ok   = nok;
        exp_rdy  = nrdy;
        exp_data = ndata;
`ifdef SWITCH_XFER_COUNT_EN
        for (int j = 0; j < N; j++) exp_cnt[j] = reset ? 32'd0 : exp_cnt[j] + 32'(nrdy[j]);
`endif
        #1;
        check_model(tag);
    endtask

    task automatic clear_inputs();
        send_ready    = '0;
        recv_request  = '0;
        send_core_idx = '0;
        recv_core_idx = '0;
    endtask

    initial begin
        int  pulses;
        logic prev, consec;

        exp_ok   = '0;
        exp_rdy  = '0;
        exp_data = '0;
`ifdef SWITCH_XFER_COUNT_EN
        exp_cnt  = '0;
`endif
        clear_inputs();
        send_data = '0;
        reset     = 1'b1;
        tick("reset0");
        tick("reset1");
        chk32("reset_data_lane", recv_data[5][3], 32'd0);
        reset = 1'b0;

        // Core 0 sends 1.0..16.0 to core 5.
        for (int k = 0; k < W; k++) send_data[0][k] = flt(k + 1);
        send_ready[0] = 1'b1; send_core_idx[0] = A'(5);
        recv_request[5] = 1'b1; recv_core_idx[5] = A'(0);
        tick("basic");
        chk32("basic_ok0", 32'(send_ok[0]), 32'd1);
        chk32("basic_rdy5", 32'(recv_ready[5]), 32'd1);
        chk32("basic_lane0", recv_data[5][0], 32'h3F80_0000);
        chk32("basic_lane15", recv_data[5][15], 32'h4180_0000);
        clear_inputs();
        tick("basic_after");
        chk32("basic_after_ok", 32'(send_ok[0]), 32'd0);
        chk32("basic_after_rdy", 32'(recv_ready[5]), 32'd0);

        // One-sided: 2 -> 4 while 4 listens to 3.
        for (int k = 0; k < W; k++) send_data[2][k] = flt(100 + k);
        send_ready[2] = 1'b1; send_core_idx[2] = A'(4);
        recv_request[4] = 1'b1; recv_core_idx[4] = A'(3);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick("onesided");
            pulses += int'(send_ok[2]) + int'(recv_ready[4]);
        end
        chk32("onesided_pulses", 32'(pulses), 32'd0);
        recv_core_idx[4] = A'(2);
        tick("onesided_fix");
        chk32("onesided_fix_rdy", 32'(recv_ready[4]), 32'd1);
        chk32("onesided_fix_lane", recv_data[4][7], flt(107));
        clear_inputs();
        tick("idle");

        // Held request: pulses only every other cycle.
        send_ready[1] = 1'b1; send_core_idx[1] = A'(2);
        recv_request[2] = 1'b1; recv_core_idx[2] = A'(1);
        pulses = 0; prev = 1'b0; consec = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick("hold");
            if (recv_ready[2] && prev) consec = 1'b1;
            prev = recv_ready[2];
            pulses += int'(recv_ready[2]);
        end
        chk32("hold_pulses", 32'(pulses), 32'd5);
        chk32("hold_consecutive", 32'(consec), 32'd0);
        clear_inputs();
        tick("idle");

        // Four parallel pairs.
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < W; k++) send_data[p][k] = flt(16 * (p + 1) + k);
            send_ready[p] = 1'b1; send_core_idx[p] = A'(7 - p);
            recv_request[7 - p] = 1'b1; recv_core_idx[7 - p] = A'(p);
        end
        tick("parallel");
        chk32("parallel_ok", 32'(send_ok), 32'h0F);
        chk32("parallel_rdy", 32'(recv_ready), 32'hF0);
        chk32("parallel_lane", recv_data[5][2], flt(16 * 3 + 2));
        clear_inputs();
        tick("idle");

        // Reset in the same cycle as a match.
        send_ready[6] = 1'b1; send_core_idx[6] = A'(1);
        recv_request[1] = 1'b1; recv_core_idx[1] = A'(6);
        reset = 1'b1;
        tick("reset_match");
        reset = 1'b0;
        clear_inputs();
        chk32("reset_match_rdy", 32'(recv_ready), 32'd0);
        chk32("reset_match_lane", recv_data[7][0], 32'd0);

        // Loopback on core 3 with -2.5 lanes.
        for (int k = 0; k < W; k++) send_data[3][k] = 32'hC020_0000;
        send_ready[3] = 1'b1; send_core_idx[3] = A'(3);
        recv_request[3] = 1'b1; recv_core_idx[3] = A'(3);
        tick("loopback");
        chk32("loopback_ok", 32'(send_ok[3]), 32'd1);
        chk32("loopback_rdy", 32'(recv_ready[3]), 32'd1);
        chk32("loopback_lane", recv_data[3][9], 32'hC020_0000);
        clear_inputs();
        tick("idle");

        // Randomized traffic, receivers often pointed at a sender that targets them.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                send_ready[i]    = ($urandom_range(0, 3) != 0);
                send_core_idx[i] = A'($urandom_range(0, N - 1));
                for (int k = 0; k < W; k++) send_data[i][k] = $urandom;
            end
            for (int j = 0; j < N; j++) begin
                recv_request[j]  = ($urandom_range(0, 3) != 0);
                recv_core_idx[j] = A'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < N; i++) begin
                        if (int'(send_core_idx[i]) == j) recv_core_idx[j] = A'(i);
                    end
                end
            end
            tick("random");
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
